// File: rtl/lsu_stage_pkg.sv
// rtl/lsu_stage_pkg.sv - shared encodings, FSM state and byte-lane helpers for the load/store stage
package lsu_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_RESP
  } state_t;

  typedef logic [3:0] be_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic be_t byte_enable(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    return be_t'(4'b0001 << off);
      2'd1:    return be_t'(4'b0011 << off);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'd0:    return {4{data[7:0]}};
      2'd1:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed lane of a read word and sign/zero-extends it
module load_align
  import lsu_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - single-outstanding load/store stage with ack timeout and writeback pulse
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    ld_funct3;
  logic [1:0]    ld_off;
  logic [31:0]   load_data;
  logic          accept, is_mem, f3_legal, misaligned, op_err, cnt_last;

  assign ready_in = (state == ST_IDLE);
  assign dmem_req = (state == ST_MEM);
  assign accept   = valid_in && ready_in;
  assign is_mem   = mem_read || mem_write;
  assign cnt_last = (wait_cnt == CNT_LAST);

  always_comb begin
    f3_legal = 1'b0;
    if (mem_write) f3_legal = (funct3 <= F3_W);
    else           f3_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  end

  assign misaligned = (funct3[1:0] == 2'b01 && alu_result[0]) ||
                      (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
  assign op_err     = is_mem && ((mem_read && mem_write) || !f3_legal || misaligned);

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (ld_off),
    .funct3 (ld_funct3),
    .data   (load_data)
  );

  // An ack on the final allowed wait cycle still completes the access
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (is_mem && !op_err) ? ST_MEM : ST_RESP;
      ST_MEM:  if (dmem_ack || cnt_last) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      ld_funct3  <= '0;
      ld_off     <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      err        <= 1'b0;
    end else begin
      state    <= state_next;
      wb_valid <= (state_next == ST_RESP);
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wb_rd    <= rd;
            wait_cnt <= '0;
            if (is_mem && !op_err) begin
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_we    <= mem_write;
              dmem_be    <= byte_enable(funct3, alu_result[1:0]);
              dmem_wdata <= store_lanes(funct3, store_data);
              ld_funct3  <= funct3;
              ld_off     <= alu_result[1:0];
            end else begin
              wb_data <= op_err ? '0 : alu_result;
              err     <= op_err;
            end
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            wb_data <= dmem_we ? '0 : load_data;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (cnt_last) begin
              wb_data <= '0;
              err     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
